sqrt_reconstruct: RTL and testbench
===================================

// Module: sqrt_reconstruct
// PURPOSE
//  Inverse companion of the iterative square-root unit: takes a root/remainder pair and rebuilds
//  the original radicand as Data = Root*Root + Reminder. Uses a sequential shift-add multiplier.
//  Sits downstream of the sqrt result path for self-check and data recovery. Uses the same
//  start/Ready handshake as the sqrt unit.
// PARAMETERS
//  WIDTH  16  width of Root and Reminder; Data is 2*WIDTH+1 bits so it cannot overflow
// PORTS
//  clk       in   1          single clock, rising edge
//  rst       in   1          reset, synchronous, active-high
//  start     in   1          launch request, level-sampled in IDLE
//  Root      in   WIDTH      square-root operand, captured when start is accepted
//  Reminder  in   WIDTH      remainder operand, captured when start is accepted
//  Data      out  2*WIDTH+1  reconstructed radicand, held until next completion
//  Ready     out  1          one-cycle completion pulse; Data valid from this cycle on
//  Busy      out  1          high whenever state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE; Data=0, Ready=0, Busy=0; internal regs cleared.
//    Applies from any state. A reset mid-operation discards the operation and raises no Ready.
//  - FSM states:
//    * IDLE: when start=1, capture Root/Reminder, clear accumulator and bit counter, go to MUL.
//    * MUL: WIDTH iterations, one per cycle, LSB first. Add the shifted multiplicand when the
//      current multiplier bit is 1. Go to ADD after iteration WIDTH.
//    * ADD: accumulator + zero-extended Reminder -> Data; Ready<=1; go to DONE.
//    * DONE: Ready<=0; go to IDLE unconditionally.
//  - Latency: start accepted at edge k -> Ready=1 and Data updated at edge k+WIDTH+1.
//    Ready returns to 0 at edge k+WIDTH+2.
//  - start is ignored in MUL/ADD/DONE; Root/Reminder changes during an operation have no effect.
//  - start held high: back-to-back operations, accepted every WIDTH+3 cycles (19 for WIDTH=16).
//  - Arithmetic is unsigned and exact. Max result (2^W-1)^2 + (2^W-1) < 2^(2W) fits in Data.
//  - Data changes only at the ADD->DONE edge or on reset; otherwise it holds its value.
// CONFIGURATION
//  SQRT_RECON_CHECK_EN defined: extra input Expected[2*WIDTH:0] captured with the operands, and
//    extra output Match (1 bit, reset 0). Match = (result==Expected), registered at the same
//    edge as Ready and held with Data.
//  Not defined: no Expected/Match ports and no comparator logic; all other behaviour identical.
// TESTING
//  1. Root=13, Reminder=3, start pulse at edge 0 (WIDTH=16) -> Ready=1 at edge 17, Data=172,
//     Ready=0 at edge 18.
//  2. Root=0, Reminder=0 -> Data=0 and Ready pulses once; Root=1, Reminder=0 -> Data=1.
//  3. Root=16'hFFFF, Reminder=16'hFFFF -> Data=33'h0_FFFF_0000 with no truncation.
//  4. start held high, Root=13, Reminder=3 -> Ready pulses at edges 17, 36, 55; Busy drops
//     for one cycle between operations.
//  5. rst=1 at edge 8 of an operation -> Busy=0, Data=0, no Ready; the next start behaves
//     exactly as in test 1.
//  6. SQRT_RECON_CHECK_EN, Root=13, Reminder=3: Expected=172 -> Match=1; Expected=173 -> Match=0.
//     Macro undefined: bench compiles with no Expected/Match ports.

Source files
------------

// File: rtl/sqrt_reconstruct.sv
// rtl/sqrt_reconstruct.sv - rebuilds a radicand from a root/remainder pair as Root*Root + Reminder
//
// Sequential shift-add multiplier with a start/Ready handshake. One operation takes WIDTH+1
// cycles from the accepting edge to the Ready pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     launch request, level-sampled while idle
//   Root      root operand, captured when start is accepted
//   Reminder  remainder operand, captured when start is accepted
//   Data      reconstructed radicand (2*WIDTH+1 bits), held until the next completion
//   Ready     one-cycle completion pulse
//   Busy      high whenever an operation is in flight
//   Expected  (SQRT_RECON_CHECK_EN only) reference radicand, captured with the operands
//   Match     (SQRT_RECON_CHECK_EN only) registered result==Expected, held with Data
//
// Optional feature macro: SQRT_RECON_CHECK_EN

module sqrt_reconstruct #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   Root,
  input  logic [WIDTH-1:0]   Reminder,
`ifdef SQRT_RECON_CHECK_EN
  input  logic [2*WIDTH:0]   Expected,
  output logic               Match,
`endif
  output logic [2*WIDTH:0]   Data,
  output logic               Ready,
  output logic               Busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   sum;

  // Root^2 fits in 2*WIDTH bits; the extra bit absorbs the remainder carry.
  assign sum  = {1'b0, acc} + {{(WIDTH+1){1'b0}}, rem_q};
  assign Busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = MUL;
      MUL:  if (cnt == CW'(WIDTH-1)) state_nx = ADD;
      ADD:  state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      rem_q  <= '0;
      cnt    <= '0;
      Data   <= '0;
      Ready  <= 1'b0;
    end else begin
      Ready <= (state == ADD);
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, Root};
            mplier <= Root;
            rem_q  <= Reminder;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          // LSB-first: multiplier shifts right while the multiplicand shifts left.
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        ADD: Data <= sum;
        default: ;
      endcase
    end
  end

`ifdef SQRT_RECON_CHECK_EN
  logic [2*WIDTH:0] exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= '0;
      Match <= 1'b0;
    end else begin
      if (state == IDLE && start) exp_q <= Expected;
      if (state == ADD)           Match <= (sum == exp_q);
    end
  end
`endif

endmodule

// File: tb/tb_sqrt_reconstruct.sv
// tb/tb_sqrt_reconstruct.sv - self-checking bench for sqrt_reconstruct against an arithmetic model

module tb_sqrt_reconstruct;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 1;
  localparam int PER   = WIDTH + 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  Root;
  logic [WIDTH-1:0]  Reminder;
  logic [2*WIDTH:0]  Data;
  logic              Ready;
  logic              Busy;
`ifdef SQRT_RECON_CHECK_EN
  logic [2*WIDTH:0]  Expected;
  logic              Match;
`endif

  int n_vec = 0;
  int n_err = 0;

  sqrt_reconstruct #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .Root     (Root),
    .Reminder (Reminder),
`ifdef SQRT_RECON_CHECK_EN
    .Expected (Expected),
    .Match    (Match),
`endif
    .Data     (Data),
    .Ready    (Ready),
    .Busy     (Busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*WIDTH:0] model(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
    longint v;
    v = longint'(r) * longint'(r) + longint'(m);
    return v[2*WIDTH:0];
  endfunction

  // One operation: start pulsed for the accepting edge only, operands scrambled afterwards.
  task automatic run_op(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m,
                        input logic [2*WIDTH:0] expv, input string name);
    logic [2*WIDTH:0] want;
    logic [2*WIDTH:0] prev;
    int               n;
    bit               seen;
    bit               held;
    want = model(r, m);
    @(negedge clk);
    prev     = Data;
    start    = 1'b1;
    Root     = r;
    Reminder = m;
`ifdef SQRT_RECON_CHECK_EN
    Expected = expv;
`endif
    @(posedge clk);
    #1;
    start    = 1'b0;
    Root     = WIDTH'($urandom);
    Reminder = WIDTH'($urandom);
`ifdef SQRT_RECON_CHECK_EN
    Expected = (2*WIDTH+1)'($urandom);
`endif
    seen = 1'b0;
    held = 1'b1;
    n    = 0;
    for (int i = 1; i <= 3 * LAT; i++) begin
      @(posedge clk);
      #1;
      if (Ready) begin
        seen = 1'b1;
        n    = i;
        break;
      end
      if (Data !== prev || Busy !== 1'b1) held = 1'b0;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s ready_timeout: got no Ready, want Ready at edge %0d", name, LAT);
      return;
    end
    n_vec++;
    if (n !== LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d, want %0d", name, n, LAT);
    end
    n_vec++;
    if (Data !== want) begin
      n_err++;
      $display("FAIL %s data: got %h, want %h", name, Data, want);
    end
    n_vec++;
    if (!held) begin
      n_err++;
      $display("FAIL %s hold_during_op: Data/Busy changed before Ready (prev Data %h)", name, prev);
    end
`ifdef SQRT_RECON_CHECK_EN
    n_vec++;
    if (Match !== (expv == want)) begin
      n_err++;
      $display("FAIL %s match: got %b, want %b", name, Match, (expv == want));
    end
`endif
    @(posedge clk);
    #1;
    n_vec++;
    if (Ready !== 1'b0 || Busy !== 1'b0 || Data !== want) begin
      n_err++;
      $display("FAIL %s after_ready: got Ready=%b Busy=%b Data=%h, want 0 0 %h",
               name, Ready, Busy, Data, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    Root = '0;
    Reminder = '0;
`ifdef SQRT_RECON_CHECK_EN
    Expected = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (Data !== '0 || Ready !== 1'b0 || Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got Data=%h Ready=%b Busy=%b, want 0 0 0", Data, Ready, Busy);
    end
`ifdef SQRT_RECON_CHECK_EN
    n_vec++;
    if (Match !== 1'b0) begin
      n_err++;
      $display("FAIL reset_match: got %b, want 0", Match);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(16'd13, 16'd3, 33'd172, "basic_13_3");
    n_vec++;
    if (Data !== 33'd172) begin
      n_err++;
      $display("FAIL basic_literal: got %0d, want 172", Data);
    end
  endtask

  task automatic test_corners();
    int pulses;
    run_op(16'd0, 16'd0, 33'd0, "zero");
    pulses = 0;
    repeat (2 * PER) begin
      @(posedge clk);
      #1;
      if (Ready) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL zero_single_pulse: got %0d extra Ready pulses, want 0", pulses);
    end
    run_op(16'd1, 16'd0, 33'd1, "one");
    run_op(16'hFFFF, 16'hFFFF, 33'h0_FFFF_0000, "max");
    n_vec++;
    if (Data !== 33'h0_FFFF_0000) begin
      n_err++;
      $display("FAIL max_literal: got %h, want 0ffff0000", Data);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] m;
    for (int i = 0; i < 20; i++) begin
      r = WIDTH'($urandom);
      m = WIDTH'($urandom);
      run_op(r, m, model(r, m), "random");
    end
  endtask

  task automatic test_back_to_back();
    int edges[$];
    int busy_low_bad;
    @(negedge clk);
    start    = 1'b1;
    Root     = 16'd13;
    Reminder = 16'd3;
`ifdef SQRT_RECON_CHECK_EN
    Expected = 33'd172;
`endif
    @(posedge clk);
    busy_low_bad = 0;
    for (int e = 1; e <= 3 * PER - 2; e++) begin
      @(posedge clk);
      #1;
      if (Ready) begin
        edges.push_back(e);
        if (Data !== 33'd172) begin
          n_err++;
          $display("FAIL b2b_data: got %0d at edge %0d, want 172", Data, e);
        end
        n_vec++;
      end
      if (e == LAT + 1 || e == LAT + 1 + PER) begin
        if (Busy !== 1'b0) busy_low_bad++;
      end
      if (e == LAT + 2 || e == LAT + 2 + PER) begin
        if (Busy !== 1'b1) busy_low_bad++;
      end
      if (e == LAT + 2 * PER) start = 1'b0;
    end
    start = 1'b0;
    n_vec++;
    if (edges.size() !== 3 || edges[0] !== LAT || edges[1] !== LAT + PER ||
        edges[2] !== LAT + 2 * PER) begin
      n_err++;
      $display("FAIL b2b_ready_edges: got %0d pulses first=%0d, want edges %0d %0d %0d",
               edges.size(), (edges.size() > 0) ? edges[0] : -1, LAT, LAT + PER, LAT + 2 * PER);
    end
    n_vec++;
    if (busy_low_bad !== 0) begin
      n_err++;
      $display("FAIL b2b_busy_gap: got %0d bad Busy samples, want 0", busy_low_bad);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    start    = 1'b1;
    Root     = 16'd13;
    Reminder = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (Busy !== 1'b0 || Data !== '0 || Ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_state: got Busy=%b Data=%h Ready=%b, want 0 0 0", Busy, Data, Ready);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (2 * PER) begin
      @(posedge clk);
      #1;
      if (Ready || Busy) pulses++;
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL mid_reset_quiet: got %0d Ready/Busy samples, want 0", pulses);
    end
    run_op(16'd13, 16'd3, 33'd172, "after_reset");
  endtask

  task automatic test_check();
`ifdef SQRT_RECON_CHECK_EN
    run_op(16'd13, 16'd3, 33'd172, "check_match");
    run_op(16'd13, 16'd3, 33'd173, "check_nomatch");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_check();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
